// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word bit positions, bubble encoding and widths.
// Used by the decoder, ID/EX and EX/MEM stages.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_CTRL_W = 14;
  localparam int unsigned PIPE_CNT_W  = 16;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned FUNCT_W     = 6;

  localparam int unsigned CTRL_MEMTOREG    = 0;
  localparam int unsigned CTRL_REGWRITE    = 1;
  localparam int unsigned CTRL_MEMWRITE    = 2;
  localparam int unsigned CTRL_MEMREAD     = 3;
  localparam int unsigned CTRL_BRANCH      = 4;
  localparam int unsigned CTRL_JUMP        = 5;
  localparam int unsigned CTRL_ALUSRC      = 6;
  localparam int unsigned CTRL_ALUOP_LSB   = 7;
  localparam int unsigned CTRL_ALUOP_MSB   = 9;
  localparam int unsigned CTRL_REGDST      = 10;
  localparam int unsigned CTRL_ALUZERO_LSB = 11;
  localparam int unsigned CTRL_ALUZERO_MSB = 13;

  // All-zero control word: no register write, no memory access, no branch/jump.
  localparam logic [PIPE_CTRL_W-1:0] CTRL_BUBBLE = 14'd0;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_e;

  // Instructions whose rt field is a source operand.
  function automatic logic reads_rt(input logic regdst, input logic memwrite,
                                    input logic branch);
    return regdst | memwrite | branch;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned CNT_W  = PIPE_CNT_W
) ();

  logic [CTRL_W-1:0]  ctrl_in;
  logic               valid_in;
  logic [DATA_W-1:0]  pc4_in;
  logic [DATA_W-1:0]  rs_data_in;
  logic [DATA_W-1:0]  rt_data_in;
  logic [DATA_W-1:0]  imm_in;
  logic [REG_W-1:0]   rs_in;
  logic [REG_W-1:0]   rt_in;
  logic [REG_W-1:0]   rd_in;
  logic [FUNCT_W-1:0] funct_in;
  logic               flush;
  logic               stall_in;

  logic [CTRL_W-1:0]  ex_ctrl;
  logic               ex_valid;
  logic [DATA_W-1:0]  ex_pc4;
  logic [DATA_W-1:0]  ex_rs_data;
  logic [DATA_W-1:0]  ex_rt_data;
  logic [DATA_W-1:0]  ex_imm;
  logic [REG_W-1:0]   ex_rs;
  logic [REG_W-1:0]   ex_rt;
  logic [REG_W-1:0]   ex_rd;
  logic [REG_W-1:0]   ex_dst;
  logic [FUNCT_W-1:0] ex_funct;
  logic               stall_out;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output ctrl_in, valid_in, pc4_in, rs_data_in, rt_data_in, imm_in,
           rs_in, rt_in, rd_in, funct_in, flush, stall_in,
    input  ex_ctrl, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_dst, ex_funct, stall_out, bubble_cnt
  );

  modport slave (
    input  ctrl_in, valid_in, pc4_in, rs_data_in, rt_data_in, imm_in,
           rs_in, rt_in, rd_in, funct_in, flush, stall_in,
    output ex_ctrl, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_dst, ex_funct, stall_out, bubble_cnt
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare between the instruction in EX and the one in ID.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic              ex_valid,
  input  reg_idx_t          ex_rt,
  input  reg_idx_t          rs_in,
  input  reg_idx_t          rt_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  output logic              load_use
);

  logic rs_hit;
  logic rt_hit;
  logic unused_ctrl;

  assign unused_ctrl = ^{ex_ctrl, ctrl_in};

  always_comb begin
    rs_hit = (ex_rt == rs_in);
    rt_hit = reads_rt(ctrl_in[CTRL_REGDST], ctrl_in[CTRL_MEMWRITE], ctrl_in[CTRL_BRANCH])
             && (ex_rt == rt_in);
    // $zero is never a real destination, so a load into it cannot create a hazard.
    load_use = valid_in && ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rt != '0)
               && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/stall priority
// and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned CNT_W  = PIPE_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  logic [CTRL_W-1:0]  ctrl_d,       ctrl_q;
  logic               valid_d,      valid_q;
  logic [DATA_W-1:0]  pc4_d,        pc4_q;
  logic [DATA_W-1:0]  rs_data_d,    rs_data_q;
  logic [DATA_W-1:0]  rt_data_d,    rt_data_q;
  logic [DATA_W-1:0]  imm_d,        imm_q;
  reg_idx_t           rs_d,         rs_q;
  reg_idx_t           rt_d,         rt_q;
  reg_idx_t           rd_d,         rd_q;
  reg_idx_t           dst_d,        dst_q;
  logic [FUNCT_W-1:0] funct_d,      funct_q;
  logic [CNT_W-1:0]   bubble_cnt_d, bubble_cnt_q;

  logic       load_use;
  stage_act_e act;

  hazard_detect #(
    .CTRL_W (CTRL_W)
  ) u_hazard (
    .ex_ctrl  (ctrl_q),
    .ex_valid (valid_q),
    .ex_rt    (rt_q),
    .rs_in    (bus.rs_in),
    .rt_in    (bus.rt_in),
    .ctrl_in  (bus.ctrl_in),
    .valid_in (bus.valid_in),
    .load_use (load_use)
  );

  always_comb begin
    act = ACT_LOAD;
    if (bus.flush)         act = ACT_FLUSH;
    else if (bus.stall_in) act = ACT_HOLD;
    else if (load_use)     act = ACT_BUBBLE;
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    valid_d      = valid_q;
    pc4_d        = pc4_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    dst_d        = dst_q;
    funct_d      = funct_q;
    bubble_cnt_d = bubble_cnt_q;

    unique case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        ctrl_d    = CTRL_W'(CTRL_BUBBLE);
        valid_d   = 1'b0;
        pc4_d     = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        dst_d     = '0;
        funct_d   = '0;
      end
      ACT_HOLD: begin
      end
      ACT_LOAD: begin
        ctrl_d    = bus.valid_in ? bus.ctrl_in : CTRL_W'(CTRL_BUBBLE);
        valid_d   = bus.valid_in;
        pc4_d     = bus.pc4_in;
        rs_data_d = bus.rs_data_in;
        rt_data_d = bus.rt_data_in;
        imm_d     = bus.imm_in;
        rs_d      = bus.rs_in;
        rt_d      = bus.rt_in;
        rd_d      = bus.rd_in;
        dst_d     = bus.ctrl_in[CTRL_REGDST] ? bus.rd_in : bus.rt_in;
        funct_d   = bus.funct_in;
      end
    endcase

    // Only hazard bubbles are counted; flush bubbles are not performance loss here.
    if ((act == ACT_BUBBLE) && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      valid_q      <= 1'b0;
      pc4_q        <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      dst_q        <= '0;
      funct_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
      pc4_q        <= pc4_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      dst_q        <= dst_d;
      funct_q      <= funct_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_ctrl    = ctrl_q;
  assign bus.ex_valid   = valid_q;
  assign bus.ex_pc4     = pc4_q;
  assign bus.ex_rs_data = rs_data_q;
  assign bus.ex_rt_data = rt_data_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_rs      = rs_q;
  assign bus.ex_rt      = rt_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_dst     = dst_q;
  assign bus.ex_funct   = funct_q;
  assign bus.bubble_cnt = bubble_cnt_q;

  // A flush discards the ID instruction anyway, so it must not freeze PC/IF-ID.
  assign bus.stall_out  = ~bus.flush & (bus.stall_in | load_use);

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 5-stage MIPS core. It sits directly downstream of the instruction-decode control unit and latches that unit's 14-bit control word together with operands, immediate and register specifiers for the EX stage. It also detects load-use hazards, inserts bubbles, honours branch/jump flushes and downstream stalls, and counts inserted bubbles for performance debug.

## Interface
- `DATA_W`, default 32: datapath width.
- `CTRL_W`, default 14: control word width.
- `CNT_W`, default 16: bubble counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ctrl_in` in CTRL_W: decoder control word. [13:11] AluzeroCtr, [10] RegDst, [9:7] ALUop, [6] ALUSrc, [5] jump, [4] Branch, [3] MemRead, [2] MemWrite, [1] RegWrite, [0] MemtoReg.
- `valid_in` in 1: IF/ID holds a real instruction.
- `pc4_in`, `rs_data_in`, `rt_data_in`, `imm_in` in DATA_W: PC+4, register-file reads, extended immediate.
- `rs_in`, `rt_in`, `rd_in` in 5: register specifiers.
- `funct_in` in 6: instruction[5:0].
- `flush` in 1: taken branch/jump resolved downstream; squash ID.
- `stall_in` in 1: downstream busy; hold the stage.
- `ex_ctrl` out CTRL_W: registered control word.
- `ex_valid` out 1.
- `ex_pc4`, `ex_rs_data`, `ex_rt_data`, `ex_imm` out DATA_W.
- `ex_rs`, `ex_rt`, `ex_rd`, `ex_dst` out 5. `ex_dst` is the write register: rd if RegDst, else rt.
- `ex_funct` out 6.
- `stall_out` out 1: combinational; holds PC and IF/ID.
- `bubble_cnt` out CNT_W: saturating count of load-use bubbles.

## Operation
- **Reads-rt condition:** ctrl_in RegDst | MemWrite | Branch.
- **load_use** = valid_in & ex_valid & ex_ctrl[3] & (ex_rt != 0) & ((ex_rt == rs_in) | (reads-rt & ex_rt == rt_in)).
- **Priority each edge:** rst > flush > stall_in > load_use > load.
  - **rst:** all registered outputs 0, bubble_cnt 0.
  - **flush:** bubble. ex_ctrl = 0, ex_valid = 0, data fields don't-care but driven 0.
  - **stall_in:** every register holds its value.
  - **load_use:** bubble, as for flush; bubble_cnt += 1, saturating at all-ones.
  - **otherwise:** load all inputs. ex_ctrl = valid_in ? ctrl_in : 0. ex_valid = valid_in.
- **stall_out** = ~flush & (stall_in | load_use).
- **Bubble invariant:** a bubble (ctrl 0) never writes a register, never accesses memory, never branches or jumps.
- **$zero:** specifier 0 never causes a hazard.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on ex_* after edge N.
- stall_out is valid in the same cycle as its inputs; it has no register.
- A load-use hazard yields exactly one bubble. After that bubble ex_ctrl[3] = 0, so the held instruction loads on the next edge.
- Simultaneous flush + load_use: flush wins. stall_out = 0 and the counter does not increment.
- Simultaneous stall_in + load_use: hold. The counter does not increment; the hazard re-evaluates after stall_in drops.
- rst asserted mid-stall or mid-bubble: the next edge clears everything. stall_out then equals stall_in.
- The counter stays at max once saturated.

## Structure
- Package `pipe_pkg`: CTRL bit-position constants (CTRL_MEMREAD = 3, CTRL_REGDST = 10, etc.), `CTRL_BUBBLE` = 14'd0, and the width constants. The package is shared with the decoder and the EX/MEM stage.
- Sub-module `hazard_detect`: purely combinational load_use compare. Inputs are ex_ctrl, ex_valid, ex_rt, rs_in, rt_in, ctrl_in and valid_in; output is load_use.
- The top level holds the pipeline registers, the priority mux and the counter.

## Test plan
- **Reset, then a plain load:** hold rst for 2 cycles, then present addi with ctrl_in = 14'h0042 and rs_in = 1, valid_in = 1. Required: all outputs 0 during reset; next cycle ex_ctrl = 14'h0042 and ex_dst = rt_in.
- **Load-use on rs:** lw $5 followed by add $6,$5,$7. Required: stall_out = 1 for one cycle, ex_ctrl = 0 for one cycle, bubble_cnt = 1, then add loads.
- **rt compare gated by reads-rt:** lw $5 followed by addi $5,$3,4 (reads-rt = 0). Required: no stall. A following sw with rt = 5 after a lw $5 stalls.
- **$zero and flush:** lw $0 followed by add using $0 gives no stall. load_use together with flush gives ex_valid = 0, stall_out = 0 and an unchanged bubble_cnt.
- **stall_in hold:** assert stall_in for 3 cycles mid-stream. Required: ex_* constant and stall_out = 1 throughout; normal flow resumes the next cycle.
- **Counter saturation:** preload the counter near max (CNT_W = 4 for the test) and drive 20 load-use pairs. Required: bubble_cnt stops at 4'hF.
